// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: FSM states, default sizing
// and the return-from-interrupt opcode decoded upstream into int_done.
package int_pkg;

    localparam int         NUM_IRQ_DEFAULT = 8;
    localparam int         CAUSE_W_DEFAULT = 3;
    localparam logic [3:0] RETI_OPCODE     = 4'b0011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } int_state_e;

    // Lowest set index of a request vector (up to 16 lines); 0 when empty.
    function automatic logic [3:0] lowest_set(input logic [15:0] vec);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) lowest_set = 4'(i);
        end
    endfunction

endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer bank for asynchronous inputs.
module int_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments here are what make meta and q two distinct
    // pipeline stages; blocking would collapse them into a single flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronizes requests, tracks pending/mask and hands
// one cause at a time to fetch. Define INT_CTRL_EDGE_EN for edge-triggered mode.
module int_ctrl
    import int_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
    parameter int CAUSE_W = CAUSE_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               int_ack,
    input  logic               int_done,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic               ipu_int,
    output logic [CAUSE_W-1:0] int_cause,
    output logic [NUM_IRQ-1:0] int_pending,
    output logic [NUM_IRQ-1:0] int_mask,
    output logic [7:0]         int_count
);

    logic [NUM_IRQ-1:0] irq_sync;
    logic [NUM_IRQ-1:0] active;
    int_state_e         state, state_next;
    logic               take;
    logic               done_take;

    int_sync #(.WIDTH(NUM_IRQ)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (irq_in),
        .q   (irq_sync)
    );

    assign active = int_pending & int_mask;

    // NOTE: every always_comb output gets a default first so no path through
    // the case statement leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        done_take  = 1'b0;
        unique case (state)
            IDLE: begin
                if (|active) begin
                    state_next = REQ;
                    take       = 1'b1;
                end
            end
            REQ: begin
                if (int_ack) state_next = SERVICE;
            end
            SERVICE: begin
                if (int_done) begin
                    state_next = IDLE;
                    done_take  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ipu_int   <= 1'b0;
            int_cause <= '0;
            int_count <= 8'd0;
        end else begin
            state   <= state_next;
            ipu_int <= (state_next == REQ);
            // Cause is captured only on IDLE->REQ, so it stays put through SERVICE.
            if (take) int_cause <= CAUSE_W'(lowest_set(16'(active)));
            if (done_take && int_count != 8'hFF) int_count <= int_count + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_mask <= '1;
        end else if (mask_we) begin
            int_mask <= mask_wdata;
        end
    end

`ifdef INT_CTRL_EDGE_EN
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] clr_vec;

    assign irq_rise = irq_sync & ~irq_prev;
    assign clr_vec  = (state == REQ && int_ack) ? (NUM_IRQ'(1) << int_cause) : '0;

    // Rise is OR-ed in after the clear so a fresh edge on the serviced line survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev    <= '0;
            int_pending <= '0;
        end else begin
            irq_prev    <= irq_sync;
            int_pending <= (int_pending & ~clr_vec) | irq_rise;
        end
    end
`else
    // Level mode: the source owns the request and deasserts it itself.
    assign int_pending = irq_sync;
`endif

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl; expected causes are queued when requests
// are driven and popped when ipu_int is raised.
module tb_int_ctrl;

    localparam int N  = 8;
    localparam int CW = 3;
`ifdef INT_CTRL_EDGE_EN
    localparam bit EDGE_MODE = 1'b1;
    localparam int LAT       = 3;
`else
    localparam bit EDGE_MODE = 1'b0;
    localparam int LAT       = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq_in;
    logic          int_ack;
    logic          int_done;
    logic          mask_we;
    logic [N-1:0]  mask_wdata;
    logic          ipu_int;
    logic [CW-1:0] int_cause;
    logic [N-1:0]  int_pending;
    logic [N-1:0]  int_mask;
    logic [7:0]    int_count;

    int            n_cmp = 0;
    int            n_mis = 0;
    logic [CW-1:0] cause_q[$];
    logic [7:0]    exp_count;

    int_ctrl #(.NUM_IRQ(N), .CAUSE_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .int_ack     (int_ack),
        .int_done    (int_done),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .ipu_int     (ipu_int),
        .int_cause   (int_cause),
        .int_pending (int_pending),
        .int_mask    (int_mask),
        .int_count   (int_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse_done();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask

    task automatic write_mask(input logic [N-1:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic bump_count();
        if (exp_count != 8'hFF) exp_count = exp_count + 8'd1;
    endtask

    // Bounded wait for ipu_int; checks edge latency and the scoreboarded cause.
    task automatic wait_ipu(input int exp_edges, input string tag);
        int            seen_at = 0;
        logic [CW-1:0] exp_cause;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ipu_int === 1'b1) begin
                seen_at = i;
                break;
            end
        end
        check({tag, "_latency"}, seen_at, exp_edges);
        check({tag, "_sb_empty"}, 32'(cause_q.size() == 0), 0);
        if (cause_q.size() != 0) begin
            exp_cause = cause_q.pop_front();
            check({tag, "_cause"}, int_cause, exp_cause);
        end
    endtask

    task automatic service_one(input int idx, input string tag);
        irq_in[idx] = 1'b1;
        cause_q.push_back(CW'(idx));
        wait_ipu(LAT + 1, tag);
        pulse_ack();
        irq_in[idx] = 1'b0;
        tick(3);
        pulse_done();
        bump_count();
        check({tag, "_count"}, int_count, exp_count);
    endtask

    initial begin
        rst        = 1'b1;
        irq_in     = '0;
        int_ack    = 1'b0;
        int_done   = 1'b0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        exp_count  = 8'd0;
        tick(3);
        rst = 1'b0;
        tick();
        check("rst_ipu",     ipu_int,     0);
        check("rst_cause",   int_cause,   0);
        check("rst_pending", int_pending, 0);
        check("rst_mask",    int_mask,    8'hFF);
        check("rst_count",   int_count,   0);

        // Single request on line 2.
        irq_in[2] = 1'b1;
        cause_q.push_back(3'd2);
        wait_ipu(LAT + 1, "a");
        check("a_pend_req", int_pending[2], 1);
        pulse_ack();
        check("a_ipu_ack", ipu_int, 0);
        check("a_pend_ack", int_pending[2], EDGE_MODE ? 0 : 1);
        irq_in[2] = 1'b0;
        tick(3);
        check("a_pend_drop", int_pending, 0);
        check("a_cause_hold", int_cause, 2);
        pulse_done();
        bump_count();
        check("a_count", int_count, exp_count);
        check("a_ipu_done", ipu_int, 0);

        // Simultaneous requests 5 and 1: lowest first, then back-to-back.
        irq_in[5] = 1'b1;
        irq_in[1] = 1'b1;
        cause_q.push_back(3'd1);
        cause_q.push_back(3'd5);
        wait_ipu(LAT + 1, "b1");
        pulse_ack();
        irq_in[1] = 1'b0;
        tick(3);
        check("b_pend_5", int_pending, 8'h20);
        pulse_done();
        bump_count();
        check("b1_count", int_count, exp_count);
        check("b1_ipu_idle", ipu_int, 0);
        wait_ipu(1, "b2");
        pulse_ack();
        irq_in[5] = 1'b0;
        tick(3);
        pulse_done();
        bump_count();
        check("b2_count", int_count, exp_count);

        // Masked request stays pending; unmasking raises ipu_int one edge later.
        write_mask(8'hFB);
        check("c_mask", int_mask, 8'hFB);
        irq_in[2] = 1'b1;
        tick(LAT + 3);
        check("c_ipu_masked", ipu_int, 0);
        check("c_pend_masked", int_pending[2], 1);
        cause_q.push_back(3'd2);
        write_mask(8'hFF);
        check("c_ipu_unmask_edge", ipu_int, 0);
        wait_ipu(1, "c");
        write_mask(8'hFB);
        check("c_ipu_no_retract", ipu_int, 1);
        write_mask(8'hFF);

        // int_done in REQ and int_ack/int_done in IDLE are ignored.
        pulse_done();
        check("d_ipu_done_in_req", ipu_int, 1);
        check("d_count_done_in_req", int_count, exp_count);
        pulse_ack();
        check("d_ipu_ack", ipu_int, 0);
        irq_in[2] = 1'b0;
        tick(3);
        pulse_done();
        bump_count();
        check("d_count", int_count, exp_count);
        pulse_ack();
        tick(2);
        check("d_ipu_ack_idle", ipu_int, 0);
        pulse_done();
        check("d_count_done_idle", int_count, exp_count);

        // Reset while in SERVICE abandons the interrupt.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        exp_count = 8'd0;
        check("e_count_zero", int_count, exp_count);
        irq_in[3] = 1'b1;
        cause_q.push_back(3'd3);
        wait_ipu(LAT + 1, "e");
        pulse_ack();
        irq_in[3] = 1'b0;
        irq_in[5] = 1'b1;
        write_mask(8'h7F);
        tick(3);
        check("e_pend_before", int_pending[5], 1);
        rst = 1'b1;
        #2;
        check("e_ipu",     ipu_int,     0);
        check("e_cause",   int_cause,   0);
        check("e_pending", int_pending, 0);
        check("e_mask",    int_mask,    8'hFF);
        check("e_count",   int_count,   0);
        irq_in[5] = 1'b0;
        tick();
        rst = 1'b0;
        tick(4);
        check("e_ipu_after", ipu_int, 0);
        check("e_count_after", int_count, 0);

        // Saturation: 257 services from zero end at 8'hFF with no wrap.
        for (int k = 0; k < 257; k++) begin
            service_one(k % N, "f");
        end
        check("f_count_sat", int_count, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
